// File: rtl/fb_scaled_vga_reader.sv
// fb_scaled_vga_reader: upscaling frame-buffer reader with VGA timing, colour bars and underflow count.
// Ports: clk25/rst_n pixel clock and async active-low reset; enable/pattern_en sampled per frame;
// fifo_q/fifo_empty/fifo_rd/fifo_reload talk to the SDRAM read FIFO; vga_* is the video output;
// frame_start marks the first active pixel; underflow_cnt holds the previous frame's empty pops.
module fb_scaled_vga_reader #(
  parameter int H_ACTIVE    = 640,
  parameter int H_FP        = 16,
  parameter int H_SYNC      = 96,
  parameter int H_BP        = 48,
  parameter int V_ACTIVE    = 480,
  parameter int V_FP        = 10,
  parameter int V_SYNC      = 2,
  parameter int V_BP        = 33,
  parameter int SCALE_SHIFT = 1,
  parameter int PIX_W       = 16
) (
  input  logic             clk25,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             pattern_en,
  input  logic [PIX_W-1:0] fifo_q,
  input  logic             fifo_empty,
  output logic             fifo_rd,
  output logic             fifo_reload,
  output logic             vga_hs,
  output logic             vga_vs,
  output logic             vga_blank_n,
  output logic [7:0]       vga_r,
  output logic [7:0]       vga_g,
  output logic [7:0]       vga_b,
  output logic             frame_start,
  output logic [15:0]      underflow_cnt
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int SRC_W   = H_ACTIVE >> SCALE_SHIFT;
  localparam int BAR_W   = H_ACTIVE / 8;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);
  localparam int AW      = $clog2(SRC_W);
  localparam logic [HW-1:0] HM = HW'((1 << SCALE_SHIFT) - 1);
  localparam logic [VW-1:0] VM = VW'((1 << SCALE_SHIFT) - 1);

  logic [HW-1:0]    h, h1;
  logic [VW-1:0]    v;
  logic             en_f, pat_f, act, fetch, h_end, v_end;
  logic             act1, fetch1, rd1, emp1, hs1, vs1, fs1;
  logic [15:0]      run;
  logic [PIX_W-1:0] lb [SRC_W];
  logic [PIX_W-1:0] lb_q, hold, src;
  logic [2:0]       bar;
  logic [23:0]      pix;

  assign h_end       = h == HW'(H_TOTAL - 1);
  assign v_end       = v == VW'(V_TOTAL - 1);
  assign act         = (h < HW'(H_ACTIVE)) && (v < VW'(V_ACTIVE));
  assign fetch       = act && ((v & VM) == '0);
  assign fifo_rd     = fetch && en_f && !pat_f && ((h & HM) == '0);
  assign fifo_reload = (h == '0) && (v == VW'(V_ACTIVE));

  // Fetch lines take the fresh FIFO word on the pop-following cycle and hold it for the replicas;
  // replay lines take the line buffer read issued one cycle earlier.
  always_comb begin
    src = fetch1 ? (rd1 ? (emp1 ? '0 : fifo_q) : hold) : lb_q;
    bar = 3'(h1 / HW'(BAR_W));
    pix = (!act1 || !en_f) ? '0 :
          pat_f ? {{8{~bar[1]}}, {8{~bar[2]}}, {8{~bar[0]}}} :
          {src[15:11], src[15:13], src[10:5], src[10:9], src[4:0], src[4:2]};
  end

  always_ff @(posedge clk25) begin
    if (rd1) lb[AW'(h1 >> SCALE_SHIFT)] <= emp1 ? '0 : fifo_q;
    if (act) lb_q <= lb[AW'(h >> SCALE_SHIFT)];
  end

  always_ff @(posedge clk25 or negedge rst_n) begin
    if (!rst_n) begin
      h <= '0;
      v <= '0;
      en_f <= 1'b0;
      pat_f <= 1'b0;
      run <= '0;
      underflow_cnt <= '0;
      h1 <= '0;
      act1 <= 1'b0;
      fetch1 <= 1'b0;
      rd1 <= 1'b0;
      emp1 <= 1'b0;
      hs1 <= 1'b1;
      vs1 <= 1'b1;
      fs1 <= 1'b0;
      hold <= '0;
      vga_hs <= 1'b1;
      vga_vs <= 1'b1;
      vga_blank_n <= 1'b0;
      frame_start <= 1'b0;
      {vga_r, vga_g, vga_b} <= '0;
    end else begin
      h <= h_end ? '0 : h + 1'b1;
      if (h_end) v <= v_end ? '0 : v + 1'b1;
      // Mode latches and underflow publication happen on the edge that enters h=0, v=0,
      // so the first pixel of the frame already sees the new mode.
      if (h_end && v_end) begin
        en_f <= enable;
        pat_f <= pattern_en;
        underflow_cnt <= run;
        run <= '0;
      end else if (fifo_rd && fifo_empty && !(&run)) run <= run + 1'b1;
      h1 <= h;
      act1 <= act;
      fetch1 <= fetch;
      rd1 <= fifo_rd;
      emp1 <= fifo_empty;
      hs1 <= !((h >= HW'(H_ACTIVE + H_FP)) && (h < HW'(H_ACTIVE + H_FP + H_SYNC)));
      vs1 <= !((v >= VW'(V_ACTIVE + V_FP)) && (v < VW'(V_ACTIVE + V_FP + V_SYNC)));
      fs1 <= (h == '0) && (v == '0);
      hold <= src;
      vga_hs <= hs1;
      vga_vs <= vs1;
      vga_blank_n <= act1;
      frame_start <= fs1;
      {vga_r, vga_g, vga_b} <= pix;
    end
  end
endmodule

// File: tb/tb_fb_scaled_vga_reader.sv
// tb_fb_scaled_vga_reader: frame-level scoreboard for the scaled VGA reader on a small raster.
module tb_fb_scaled_vga_reader;
  localparam int HA = 32, HF = 4, HS = 8, HB = 4;
  localparam int VA = 16, VF = 2, VS = 2, VB = 2;
  localparam int S = 1;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int FT = HT * VT;
  localparam int SW = HA >> S;
  localparam int BW = HA / 8;
  localparam int NPOP = SW * (VA >> S);
  localparam int UF_K = 20;
  localparam logic [23:0] BARS [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                                       24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

  logic clk25, rst_n, enable, pattern_en, fifo_empty, fifo_rd, fifo_reload;
  logic vga_hs, vga_vs, vga_blank_n, frame_start;
  logic [15:0] fifo_q, underflow_cnt;
  logic [7:0] vga_r, vga_g, vga_b;

  fb_scaled_vga_reader #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .SCALE_SHIFT(S), .PIX_W(16)
  ) dut (
    .clk25(clk25), .rst_n(rst_n), .enable(enable), .pattern_en(pattern_en),
    .fifo_q(fifo_q), .fifo_empty(fifo_empty), .fifo_rd(fifo_rd), .fifo_reload(fifo_reload),
    .vga_hs(vga_hs), .vga_vs(vga_vs), .vga_blank_n(vga_blank_n),
    .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
    .frame_start(frame_start), .underflow_cnt(underflow_cnt)
  );

  initial clk25 = 1'b0;
  always #5 clk25 = ~clk25;

  typedef struct {
    bit en;
    bit pat;
    bit uf;
    logic [15:0] base;
    int exp_pops;
    int exp_ufc;
  } row_t;
  row_t tab [8];

  bit en_t [64], pat_t [64], uf_t [64];
  logic [15:0] base_t [64];
  int n, pops, prev_pops, exp_ufc, tests, fails, pend_f, pend_k;
  bit pend, next_uf;
  logic [15:0] next_base;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      if (fails <= 40) $display("FAIL %s at cycle %0d: got %0h, expected %0h", nm, n, act, exp);
    end
  endtask

  function automatic logic [23:0] expand(input logic [15:0] c);
    return {c[15:11], c[15:13], c[10:5], c[10:9], c[4:0], c[4:2]};
  endfunction

  // Expected RGB for raster position q counted from reset release.
  function automatic logic [23:0] exp_pix(input int q);
    int x, y, f, k;
    x = q % HT;
    y = (q / HT) % VT;
    f = (q / FT) % 64;
    if (x >= HA || y >= VA || !en_t[f]) return 24'h0;
    if (pat_t[f]) return BARS[x / BW];
    k = (y >> S) * SW + (x >> S);
    if (uf_t[f] && k >= UF_K && k < UF_K + 10) return 24'h0;
    return expand(16'(base_t[f] + k));
  endfunction

  task automatic check_reset(input string nm);
    chk({nm, "_sync"}, {vga_hs, vga_vs, vga_blank_n, frame_start}, 4'b1100);
    chk({nm, "_rgb"}, {vga_r, vga_g, vga_b}, 0);
    chk({nm, "_fifo"}, {fifo_rd, fifo_reload}, 0);
    chk({nm, "_ufcnt"}, underflow_cnt, 0);
  endtask

  // One cycle of model + checks + FIFO behaviour, called at each falling edge.
  task automatic eval();
    int p, f, x, y, q, qx, qy;
    logic [23:0] rgb_e;
    logic [3:0] sy_e;
    p = n;
    f = (p / FT) % 64;
    x = p % HT;
    y = (p / HT) % VT;
    if (p % FT == 0) begin
      if (p > 0) begin
        int g;
        g = (p / FT - 1) % 64;
        exp_ufc = (en_t[g] && !pat_t[g] && uf_t[g]) ? 10 : 0;
        en_t[f] = enable;
        pat_t[f] = pattern_en;
      end else begin
        exp_ufc = 0;
        en_t[f] = 1'b0;
        pat_t[f] = 1'b0;
      end
      uf_t[f] = next_uf;
      base_t[f] = next_base;
      prev_pops = pops;
      pops = 0;
    end
    q = p - 2;
    if (q < 0) begin
      sy_e = 4'b1100;
      rgb_e = 24'h0;
    end else begin
      qx = q % HT;
      qy = (q / HT) % VT;
      sy_e = {!(qx >= HA + HF && qx < HA + HF + HS), !(qy >= VA + VF && qy < VA + VF + VS),
              qx < HA && qy < VA, qx == 0 && qy == 0};
      rgb_e = exp_pix(q);
    end
    chk("sync", {vga_hs, vga_vs, vga_blank_n, frame_start}, sy_e);
    chk("rgb", {vga_r, vga_g, vga_b}, rgb_e);
    chk("fifo_rd", fifo_rd, x < HA && y < VA && en_t[f] && !pat_t[f] &&
        y % (1 << S) == 0 && x % (1 << S) == 0);
    chk("fifo_reload", fifo_reload, x == 0 && y == VA);
    chk("underflow_cnt", underflow_cnt, exp_ufc);
    fifo_q = pend ? 16'(base_t[pend_f] + pend_k) : 16'($urandom);
    if (fifo_rd) begin
      pend = 1'b1;
      pend_f = f;
      pend_k = pops;
      fifo_empty = uf_t[f] && pops >= UF_K && pops < UF_K + 10;
      pops++;
    end else begin
      pend = 1'b0;
      fifo_empty = 1'($urandom);
    end
  endtask

  task automatic step();
    @(negedge clk25);
    n++;
    eval();
  endtask

  task automatic to_boundary();
    do step(); while (n % FT != 0);
  endtask

  initial begin
    int c;
    tab[0] = '{1'b1, 1'b0, 1'b0, 16'h0000, NPOP, 0};
    tab[1] = '{1'b1, 1'b0, 1'b1, 16'h0000, NPOP, 10};
    tab[2] = '{1'b1, 1'b0, 1'b0, 16'hFFC0, NPOP, 0};
    tab[3] = '{1'b1, 1'b1, 1'b0, 16'h0000, 0, 0};
    tab[4] = '{1'b0, 1'b0, 1'b0, 16'h0000, 0, 0};
    tab[5] = '{1'b0, 1'b1, 1'b1, 16'h0000, 0, 0};
    tab[6] = '{1'b1, 1'b0, 1'b1, 16'h0000, NPOP, 10};
    tab[7] = '{1'b1, 1'b1, 1'b1, 16'h0000, 0, 0};
    tests = 0; fails = 0; n = 0; pops = 0; prev_pops = 0; pend = 1'b0;
    rst_n = 1'b0; enable = 1'b0; pattern_en = 1'b0; fifo_q = '0; fifo_empty = 1'b0;
    next_uf = 1'b0; next_base = '0;
    repeat (3) @(negedge clk25);
    check_reset("reset");
    rst_n = 1'b1;
    eval();
    for (int i = 0; i <= 8; i++) begin
      if (i < 8) begin
        enable = tab[i].en;
        pattern_en = tab[i].pat;
        next_uf = tab[i].uf;
        next_base = (tab[i].base != 0) ? tab[i].base : 16'($urandom);
      end else begin
        enable = 1'b1;
        pattern_en = 1'b0;
        next_uf = 1'b1;
        next_base = 16'($urandom);
      end
      to_boundary();
      if (i > 0) begin
        chk("frame_pops", prev_pops, tab[i-1].exp_pops);
        chk("frame_ufcnt", underflow_cnt, tab[i-1].exp_ufc);
      end
      repeat (FT / 3) step();
      enable = 1'($urandom);
      pattern_en = 1'($urandom);
    end
    enable = 1'b1;
    pattern_en = 1'b0;
    next_uf = 1'b0;
    to_boundary();
    chk("ufcnt_before_reset", underflow_cnt, 10);
    repeat (5 * HT + 7) step();
    #2 rst_n = 1'b0;
    #1 check_reset("midreset");
    @(negedge clk25);
    check_reset("midreset_hold");
    @(negedge clk25);
    n = 0; pops = 0; pend = 1'b0;
    rst_n = 1'b1;
    eval();
    c = 0;
    while (vga_hs && c < 200) begin
      step();
      c++;
    end
    chk("hs_fall_after_reset", n, HA + HF + 2);
    to_boundary();
    to_boundary();
    chk("frame_pops_after_reset", prev_pops, NPOP);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/fb_scaled_vga_reader.md
Name: fb_scaled_vga_reader

Overview:
- Display-side frame-buffer reader in the clk25 domain.
- Pulls RGB565 pixels from an SDRAM read-port FIFO (normal mode: q valid one cycle after rd) and generates parametrised VGA timing.
- Upscales the source frame by 2^SCALE_SHIFT in both axes using a one-line buffer, so a 320x240 camera frame fills a 640x480 screen.
- Also provides a colour-bar test mode, a FIFO reload pulse per frame, and underflow accounting.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (clocks)
- H_SYNC, 96, horizontal sync width
- H_BP, 48, horizontal back porch
- V_ACTIVE, 480, visible lines
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width
- V_BP, 33, vertical back porch
- SCALE_SHIFT, 1, upscale factor 2^SCALE_SHIFT (0..2); source width SRC_W = H_ACTIVE>>SCALE_SHIFT
- PIX_W, 16, FIFO pixel width (RGB565 packing [15:11] R, [10:5] G, [4:0] B)

Ports:
- clk25  in  1  pixel clock
- rst_n  in  1  asynchronous active-low reset
- enable  in  1  fetch/display enable, sampled at frame boundary
- pattern_en  in  1  colour-bar mode, sampled at frame boundary
- fifo_q  in  PIX_W  read FIFO data
- fifo_empty  in  1  read FIFO empty
- fifo_rd  out  1  read FIFO pop request
- fifo_reload  out  1  one-cycle pulse reloading the FIFO read address
- vga_hs  out  1  horizontal sync, active low
- vga_vs  out  1  vertical sync, active low
- vga_blank_n  out  1  high during active video
- vga_r  out  8  red
- vga_g  out  8  green
- vga_b  out  8  blue
- frame_start  out  1  one-cycle pulse, aligned with the first active pixel output
- underflow_cnt  out  16  saturating count of pops attempted while empty in the last completed frame

Behaviour:
- Reset values: vga_hs=1, vga_vs=1, vga_blank_n=0, RGB=0, fifo_rd=0, fifo_reload=0, frame_start=0, underflow_cnt=0. All counters and the line buffer pointer are 0. Line buffer contents are don't-care.
- Counters:
  - h counts 0..H_TOTAL-1 and wraps; H_TOTAL = sum of the four H parameters.
  - v increments on h wrap and counts 0..V_TOTAL-1; defaults give 800x525.
  - Active region: h<H_ACTIVE and v<V_ACTIVE.
  - HS is low for H_ACTIVE+H_FP <= h < H_ACTIVE+H_FP+H_SYNC; VS uses the analogous v rule.
- Frame boundary: at h=0, v=0, latch enable -> en_f and pattern_en -> pat_f, and publish the running underflow count to underflow_cnt, then clear the running count.
- fifo_reload: one-cycle pulse at h=0, v=V_ACTIVE (start of vertical blanking), asserted regardless of en_f.
- Fetch lines: active lines with v[SCALE_SHIFT-1:0]==0.
  - fifo_rd=1 when active, en_f=1, pat_f=0, and h[SCALE_SHIFT-1:0]==0. This gives exactly SRC_W pops per fetch line and none elsewhere.
  - The popped word is written to the line buffer at h>>SCALE_SHIFT one cycle later. The same word drives the pixel output for every replica of that pixel: it is held for 2^SCALE_SHIFT clocks.
- Replay lines: the other active lines read the line buffer (synchronous RAM, latency 1) at address h>>SCALE_SHIFT and perform no pops.
- Latency: pixel data reaches the outputs 2 clocks after its h/v counter state. HS, VS and blank_n are delayed 2 clocks so all outputs stay aligned.
- Underflow: fifo_rd asserted while fifo_empty=1 increments the running count, saturating at 16'hFFFF. The pixel output shows 0 (black) and the line buffer stores 0. fifo_rd is still asserted so the FIFO address stays in step.
- en_f=0: no pops; active pixels are black; sync is unaffected.
- pat_f=1: active pixels show 8 vertical bars of width H_ACTIVE/8 in the order white, yellow, cyan, green, magenta, red, blue, black. No pops occur in this mode.
- Colour expansion:
  - r8 = {r5, r5[4:2]}
  - g8 = {g6, g6[5:4]}
  - b8 = {b5, b5[4:2]}
- Outside active video, RGB=0 and blank_n=0.
- enable or pattern_en changing mid-frame has no effect until the next frame boundary.
- Reset mid-frame: all outputs immediately return to reset values and timing restarts at h=0, v=0.

Test Plan:
- Reset/timing: release reset and run 2 frames. Required: HS low for 96 clocks every 800 clocks; VS low for 2 lines every 525 lines; blank_n high for 640 clocks on 480 lines; frame_start once per 420000 clocks.
- Fetch count: enable=1, FIFO never empty. Required per frame: exactly 76800 fifo_rd cycles, only on even v and even h; one fifo_reload pulse at v=480, h=0.
- Scaling correctness: FIFO model returns an incrementing index k. Required: output at active (x,y) = RGB expansion of (y>>1)*320+(x>>1); a source value of 16'hFFFF yields RGB=FF,FF,FF.
- Underflow: hold fifo_empty=1 for 10 pops in frame N. Required: those pixels (and their replicas) are black; underflow_cnt=10 after the next frame boundary, then 0 after a clean frame N+1.
- Mode switching: assert pattern_en mid-frame. Required: the current frame is unchanged; the next frame shows bars (first bar FF,FF,FF; bar at x=560 is 00,00,00) with zero fifo_rd; deasserting enable gives black output with sync intact.
- Reset mid-operation: pulse rst_n low at v=100. Required: all outputs return to reset values immediately; after release the first HS falling edge occurs 656+2 clocks later.
